board_tile_scanner: RTL and testbench

Pixel-to-board lookup stage that sits directly upstream of the per-piece sprite blocks. For every DrawX/DrawY it computes which of the 64 board squares is being scanned. It then outputs that square's piece code, the sprite's top-left offsetX/offsetY, and the checker shade. It holds the 64-square board state and applies game-logic move writes through a small FIFO, only during vertical blank, so a frame never tears.

---
 rtl/board_tile_scanner.sv | 208 ++++++++++++++++++++
 tb/tb_board_tile_scanner.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_tile_scanner.sv
// -----------------------------------------------------------------------------
// board_tile_scanner
//
// Pixel-to-board lookup stage for an 8x8 chess board drawn on a VGA raster.
// For every scan pixel it registers the scanned square's piece code, the
// top-left corner of the 55x55 sprite centred in that square, and the checker
// shade. It owns the 64-square board state. Move writes from game logic are
// queued in a small FIFO and applied only during vertical blank, so a frame
// never shows a half-updated board.
//
// Ports
//   vga_clk              pixel clock, all state on its rising edge
//   reset_n              asynchronous active-low reset
//   DrawX, DrawY         current scan pixel
//   vblank               high during vertical blanking (FIFO drains)
//   wr_valid/wr_ready    write handshake from game logic
//   wr_square, wr_piece  write payload: square (row*8+col) and piece code
//   pending              number of queued writes
//   tile_on              pixel lies inside the board
//   piece_code           piece code of the scanned square (0 off-board)
//   offsetX, offsetY     sprite top-left for the scanned square (0 off-board)
//   tile_dark            scanned square is dark (0 off-board)
//   DrawX_d, DrawY_d     scan pixel delayed to line up with the outputs above
// -----------------------------------------------------------------------------
module board_tile_scanner #(
   parameter int ORIGIN_X   = 80,
   parameter int ORIGIN_Y   = 0,
   parameter int TILE       = 60,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       vga_clk,
   input  logic       reset_n,
   input  logic [9:0] DrawX,
   input  logic [9:0] DrawY,
   input  logic       vblank,
   input  logic       wr_valid,
   input  logic [5:0] wr_square,
   input  logic [3:0] wr_piece,
   output logic       wr_ready,
   output logic [2:0] pending,
   output logic       tile_on,
   output logic [3:0] piece_code,
   output logic [9:0] offsetX,
   output logic [9:0] offsetY,
   output logic       tile_dark,
   output logic [9:0] DrawX_d,
   output logic [9:0] DrawY_d
);

   localparam int         PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [9:0] LP_OX     = 10'(ORIGIN_X);
   localparam logic [9:0] LP_OY     = 10'(ORIGIN_Y);
   localparam logic [9:0] LP_SPAN   = 10'(8 * TILE);
   localparam logic [9:0] LP_CENTRE = 10'((TILE - 55) / 2);
   localparam logic [2:0] LP_DEPTH  = 3'(FIFO_DEPTH);

   // Opening position: black back rank on row 0, white back rank on row 7.
   function automatic logic [3:0] f_start_piece(input int sq);
      logic [3:0] back;
      case (sq % 8)
         0, 7:    back = 4'd4;  // rook
         1, 6:    back = 4'd2;  // knight
         2, 5:    back = 4'd3;  // bishop
         3:       back = 4'd5;  // queen
         default: back = 4'd6;  // king
      endcase
      case (sq / 8)
         0:       return back | 4'd8;
         1:       return 4'd9;
         6:       return 4'd1;
         7:       return back;
         default: return 4'd0;
      endcase
   endfunction

   function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   // ---------------- tile decode ----------------
   logic [10:0] w_rx_ext, w_ry_ext;
   logic [9:0]  w_rx, w_ry, w_tile_x, w_tile_y;
   logic [2:0]  w_col, w_row;
   logic        w_in_board;
   logic [5:0]  w_sq;

   // The extra top bit is the borrow, i.e. DrawX < ORIGIN_X.
   assign w_rx_ext   = {1'b0, DrawX} - {1'b0, LP_OX};
   assign w_ry_ext   = {1'b0, DrawY} - {1'b0, LP_OY};
   assign w_rx       = w_rx_ext[9:0];
   assign w_ry       = w_ry_ext[9:0];
   assign w_in_board = !w_rx_ext[10] && (w_rx < LP_SPAN) &&
                       !w_ry_ext[10] && (w_ry < LP_SPAN);
   assign w_sq       = {w_row, w_col};

   // Compare chain against multiples of TILE replaces a divider.
   always_comb begin
      // NOTE: every signal gets a default before the loop so no latch is inferred.
      w_col    = '0;
      w_row    = '0;
      w_tile_x = '0;
      w_tile_y = '0;
      for (int i = 1; i < 8; i++) begin
         if (w_rx >= 10'(i * TILE)) begin
            w_col    = 3'(i);
            w_tile_x = 10'(i * TILE);
         end
         if (w_ry >= 10'(i * TILE)) begin
            w_row    = 3'(i);
            w_tile_y = 10'(i * TILE);
         end
      end
   end

   // ---------------- write FIFO ----------------
   logic [5:0]       r_fifo_sq [FIFO_DEPTH];
   logic [3:0]       r_fifo_pc [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
   logic [2:0]       r_count;
   logic             w_push, w_pop;

   assign wr_ready = (r_count != LP_DEPTH);
   assign pending  = r_count;
   assign w_push   = wr_valid && wr_ready;
   assign w_pop    = vblank && (r_count != 3'd0);

   // FIFO payload needs no reset: r_count gates every read of it.
   always_ff @(posedge vga_clk) begin
      if (w_push) begin
         r_fifo_sq[r_wr_ptr] <= wr_square;
         r_fifo_pc[r_wr_ptr] <= wr_piece;
      end
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= f_next(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= f_next(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 3'd1;
            2'b01:   r_count <= r_count - 3'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // ---------------- board state ----------------
   logic [3:0] r_board [64];

   // NOTE: the board is a register array that must come out of reset holding
   // the opening position, so it is reset element by element; the FIFO payload
   // above is deliberately left unreset.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 64; i++) r_board[i] <= f_start_piece(i);
      end else if (w_pop) begin
         r_board[r_fifo_sq[r_rd_ptr]] <= r_fifo_pc[r_rd_ptr];
      end
   end

   // ---------------- registered outputs ----------------
   logic       r_tile_on, r_tile_dark;
   logic [3:0] r_piece_code;
   logic [9:0] r_offset_x, r_offset_y, r_drawx_d, r_drawy_d;

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_tile_on    <= 1'b0;
         r_piece_code <= '0;
         r_offset_x   <= '0;
         r_offset_y   <= '0;
         r_tile_dark  <= 1'b0;
         r_drawx_d    <= '0;
         r_drawy_d    <= '0;
      end else begin
         r_drawx_d <= DrawX;
         r_drawy_d <= DrawY;
         if (w_in_board) begin
            // NOTE: non-blocking assignment means a pop on this same edge is
            // not yet visible here; the new value shows on the next decode.
            r_tile_on    <= 1'b1;
            r_piece_code <= r_board[w_sq];
            r_offset_x   <= LP_OX + w_tile_x + LP_CENTRE;
            r_offset_y   <= LP_OY + w_tile_y + LP_CENTRE;
            r_tile_dark  <= w_row[0] ^ w_col[0];
         end else begin
            r_tile_on    <= 1'b0;
            r_piece_code <= '0;
            r_offset_x   <= '0;
            r_offset_y   <= '0;
            r_tile_dark  <= 1'b0;
         end
      end
   end

   assign tile_on    = r_tile_on;
   assign piece_code = r_piece_code;
   assign offsetX    = r_offset_x;
   assign offsetY    = r_offset_y;
   assign tile_dark  = r_tile_dark;
   assign DrawX_d    = r_drawx_d;
   assign DrawY_d    = r_drawy_d;

endmodule

// File: tb/tb_board_tile_scanner.sv
// -----------------------------------------------------------------------------
// tb_board_tile_scanner
//
// Directed bench for board_tile_scanner. Pixel probes push their hand-computed
// expected decode into a scoreboard queue; a monitor pops and compares one
// cycle later when the delayed probe flag says the DUT is presenting it.
// FIFO occupancy and handshake are checked inline around each write sequence.
// -----------------------------------------------------------------------------
module tb_board_tile_scanner;

   logic       clk;
   logic       reset_n;
   logic [9:0] draw_x, draw_y;
   logic       vblank;
   logic       wr_valid;
   logic [5:0] wr_square;
   logic [3:0] wr_piece;
   logic       wr_ready;
   logic [2:0] pending;
   logic       tile_on;
   logic [3:0] piece_code;
   logic [9:0] offset_x, offset_y;
   logic       tile_dark;
   logic [9:0] draw_x_d, draw_y_d;

   board_tile_scanner dut (
      .vga_clk    (clk),
      .reset_n    (reset_n),
      .DrawX      (draw_x),
      .DrawY      (draw_y),
      .vblank     (vblank),
      .wr_valid   (wr_valid),
      .wr_square  (wr_square),
      .wr_piece   (wr_piece),
      .wr_ready   (wr_ready),
      .pending    (pending),
      .tile_on    (tile_on),
      .piece_code (piece_code),
      .offsetX    (offset_x),
      .offsetY    (offset_y),
      .tile_dark  (tile_dark),
      .DrawX_d    (draw_x_d),
      .DrawY_d    (draw_y_d)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int x, y, on, pc, ox, oy, dark;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;
   logic probe    = 1'b0;
   logic probe_d  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Flag lines up with the DUT's one-cycle decode latency.
   always @(posedge clk) probe_d <= probe;

   always @(negedge clk) begin
      if (probe_d) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_underflow: got empty queue expected an entry");
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check($sformatf("DrawX_d(%0d,%0d)", e.x, e.y), 32'(draw_x_d), e.x);
            check($sformatf("DrawY_d(%0d,%0d)", e.x, e.y), 32'(draw_y_d), e.y);
            check($sformatf("tile_on(%0d,%0d)", e.x, e.y), 32'(tile_on), e.on);
            check($sformatf("piece(%0d,%0d)", e.x, e.y), 32'(piece_code), e.pc);
            check($sformatf("offsetX(%0d,%0d)", e.x, e.y), 32'(offset_x), e.ox);
            check($sformatf("offsetY(%0d,%0d)", e.x, e.y), 32'(offset_y), e.oy);
            check($sformatf("dark(%0d,%0d)", e.x, e.y), 32'(tile_dark), e.dark);
         end
      end
   end

   // All stimulus steps start at posedge+1 and end there too.
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_probe(input int x, input int y, input int on, input int pc,
                           input int ox, input int oy, input int dark);
      exp_t e;
      e = '{x: x, y: y, on: on, pc: pc, ox: ox, oy: oy, dark: dark};
      draw_x = 10'(x);
      draw_y = 10'(y);
      probe  = 1'b1;
      sb_q.push_back(e);
      cyc(1);
      probe = 1'b0;
   endtask

   task automatic write_one(input int sq, input int pc);
      wr_valid  = 1'b1;
      wr_square = 6'(sq);
      wr_piece  = 4'(pc);
      cyc(1);
      wr_valid  = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_tile_on"}, 32'(tile_on), 0);
      check({tag, "_piece"},   32'(piece_code), 0);
      check({tag, "_offsetX"}, 32'(offset_x), 0);
      check({tag, "_offsetY"}, 32'(offset_y), 0);
      check({tag, "_dark"},    32'(tile_dark), 0);
      check({tag, "_DrawX_d"}, 32'(draw_x_d), 0);
      check({tag, "_DrawY_d"}, 32'(draw_y_d), 0);
      check({tag, "_pending"}, 32'(pending), 0);
      check({tag, "_wr_ready"}, 32'(wr_ready), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int fsq[5];
      int fpc[5];
      fsq = '{16, 17, 18, 19, 20};
      fpc = '{5, 6, 7, 8, 15};

      reset_n   = 1'b0;
      draw_x    = '0;
      draw_y    = '0;
      vblank    = 1'b0;
      wr_valid  = 1'b0;
      wr_square = '0;
      wr_piece  = '0;
      #12;
      check_reset_state("por");
      #2 reset_n = 1'b1;
      cyc(1);

      // Corners and edges on the opening position.
      do_probe( 80,   0, 1, 12,  82,   2, 0);
      do_probe(559, 479, 1,  4, 502, 422, 0);
      do_probe(139,   0, 1, 12,  82,   2, 0);
      do_probe(140,   0, 1, 10, 142,   2, 1);
      do_probe( 79,   0, 0,  0,   0,   0, 0);
      do_probe(560,   0, 0,  0,   0,   0, 0);
      do_probe( 80, 480, 0,  0,   0,   0, 0);
      draw_x = 10'd300;
      draw_y = 10'd200;
      cyc(1);

      // Reset asserted mid-stream, between clock edges.
      #2 reset_n = 1'b0;
      #1 check_reset_state("mid_reset");
      #3 reset_n = 1'b1;
      cyc(1);
      do_probe(80, 0, 1, 12, 82, 2, 0);

      // Write deferral: nothing lands until vblank.
      write_one(52, 0);
      check("defer_pending", 32'(pending), 1);
      do_probe(320, 360, 1, 1, 322, 362, 0);
      check("defer_pending_held", 32'(pending), 1);
      vblank = 1'b1;
      cyc(1);
      vblank = 1'b0;
      check("defer_drained", 32'(pending), 0);
      do_probe(320, 360, 1, 0, 322, 362, 0);

      // FIFO full: fifth write held until a pop frees a slot.
      for (int k = 0; k < 4; k++) begin
         wr_valid  = 1'b1;
         wr_square = 6'(fsq[k]);
         wr_piece  = 4'(fpc[k]);
         check($sformatf("fill_ready_%0d", k), 32'(wr_ready), 1);
         check($sformatf("fill_pending_%0d", k), 32'(pending), k);
         cyc(1);
      end
      wr_square = 6'(fsq[4]);
      wr_piece  = 4'(fpc[4]);
      check("full_pending", 32'(pending), 4);
      check("full_ready", 32'(wr_ready), 0);
      cyc(1);
      check("full_held_pending", 32'(pending), 4);
      check("full_held_ready", 32'(wr_ready), 0);
      vblank = 1'b1;
      cyc(1);
      check("pop1_pending", 32'(pending), 3);
      check("pop1_ready", 32'(wr_ready), 1);
      cyc(1);
      wr_valid = 1'b0;
      check("pushpop_pending", 32'(pending), 3);
      cyc(1);
      check("pop3_pending", 32'(pending), 2);
      cyc(1);
      check("pop4_pending", 32'(pending), 1);
      cyc(1);
      check("pop5_pending", 32'(pending), 0);
      vblank = 1'b0;
      do_probe( 80, 120, 1,  5,  82, 122, 0);
      do_probe(140, 120, 1,  6, 142, 122, 1);
      do_probe(200, 120, 1,  7, 202, 122, 0);
      do_probe(260, 120, 1,  8, 262, 122, 1);
      do_probe(320, 120, 1, 15, 322, 122, 0);

      // Ordering: last write to a square wins.
      write_one(12, 9);
      write_one(12, 0);
      check("order_pending", 32'(pending), 2);
      vblank = 1'b1;
      cyc(2);
      vblank = 1'b0;
      check("order_drained", 32'(pending), 0);
      do_probe(320, 60, 1, 0, 322, 62, 1);

      // Partial drain: two entries carry over to the next vblank.
      for (int k = 0; k < 4; k++) write_one(40 + k, 2 + k);
      check("partial_full", 32'(pending), 4);
      vblank = 1'b1;
      cyc(2);
      vblank = 1'b0;
      check("partial_left", 32'(pending), 2);
      do_probe( 80, 300, 1, 2,  82, 302, 1);
      do_probe(200, 300, 1, 0, 202, 302, 1);
      check("partial_held", 32'(pending), 2);
      vblank = 1'b1;
      cyc(2);
      vblank = 1'b0;
      check("partial_done", 32'(pending), 0);
      do_probe(200, 300, 1, 4, 202, 302, 1);
      do_probe(260, 300, 1, 5, 262, 302, 0);

      // Reset mid-drain restores the opening position.
      for (int k = 0; k < 4; k++) write_one(k, 0);
      vblank = 1'b1;
      cyc(1);
      check("middrain_pending", 32'(pending), 3);
      #2 reset_n = 1'b0;
      #1 check_reset_state("drain_reset");
      vblank = 1'b0;
      #3 reset_n = 1'b1;
      cyc(1);
      do_probe( 80,   0, 1, 12,  82,   2, 0);
      do_probe(140,   0, 1, 10, 142,   2, 1);
      do_probe( 80, 300, 1,  0,  82, 302, 1);
      do_probe(320, 360, 1,  1, 322, 362, 0);
      do_probe(320,  60, 1,  9, 322,  62, 1);
      do_probe(320, 120, 1,  0, 322, 122, 0);
      do_probe(559, 479, 1,  4, 502, 422, 0);

      cyc(2);
      check("scoreboard_empty", 32'(sb_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
